// File: rtl/ram_sweep_dp.sv
// ram_sweep_dp: single-clock RAM with one write port and one read port.
// A hardware sweep zeroes every word after reset and on clr. Reads are
// registered (latency 1) with write-first bypass on address collision, and
// out-of-range accesses are dropped and flagged on err.
module ram_sweep_dp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] d,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic              err
);

    // Range checks are done one bit wider than the address so that
    // DEPTH == 2**ADDR_W is representable and no address is truncated.
    localparam int unsigned       AW1     = ADDR_W + 1;
    localparam logic [AW1-1:0]    DEPTH_X = AW1'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    // Array index width; only used once an address is known to be in range.
    localparam int unsigned       IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {StClear, StIdle} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              w_ok, r_ok;
    logic              sweep_we, wr_en, rd_en, err_d;
    logic [DATA_W-1:0] rd_data;
    logic [IW-1:0]     w_idx, r_idx, p_idx;

    assign w_ok  = {1'b0, waddr} < DEPTH_X;
    assign r_ok  = {1'b0, raddr} < DEPTH_X;
    assign w_idx = waddr[IW-1:0];
    assign r_idx = raddr[IW-1:0];
    assign p_idx = ptr_q[IW-1:0];

    // State register: reset lands in the sweep with the pointer at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: sweep until the last word is written, restart on clr.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StClear: begin
                if (ptr_q == LAST) begin
                    state_d = StIdle;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            default: state_d = StClear;
        endcase
    end

    // FSM outputs: user ports are only honoured while idle.
    always_comb begin
        busy     = (state_q == StClear);
        sweep_we = (state_q == StClear);
        wr_en    = (state_q == StIdle) && load && w_ok;
        rd_en    = (state_q == StIdle) && ren;
        err_d    = (state_q == StIdle) && ((load && !w_ok) || (ren && !r_ok));
    end

    // Read data selection: out-of-range reads return zero, collisions forward d.
    always_comb begin
        rd_data = '0;
        if (r_ok) begin
            if (wr_en && (waddr == raddr)) begin
                rd_data = d;
            end else begin
                rd_data = mem[r_idx];
            end
        end
    end

    // Storage array: the sweep owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[p_idx] <= '0;
        end else if (wr_en) begin
            mem[w_idx] <= d;
        end
    end

    // Registered read port and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            q_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            q_valid <= rd_en;
            err     <= err_d;
            if (rd_en) begin
                q <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_sweep_dp.sv
// Testbench for ram_sweep_dp (DEPTH=16, ADDR_W=5): fixed vector table,
// hand-written sweep/reset sequences and random traffic against a model.
module tb_ram_sweep_dp;

    localparam int DW  = 16;
    localparam int AW  = 5;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          rst, clr, load, ren;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] d, q;
    logic          q_valid, busy, err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: whole-array clear, sweep tracked as a cycle count.
    logic [DW-1:0] mm [DEP];
    logic [DW-1:0] mq;
    logic          mqv, merr;
    int            mcnt;

    typedef struct {
        logic          c;
        logic          l;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          r;
        logic [AW-1:0] ra;
        logic [DW-1:0] eq;
        logic          eqv;
        logic          eerr;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    ram_sweep_dp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .load    (load),
        .waddr   (waddr),
        .d       (d),
        .ren     (ren),
        .raddr   (raddr),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy),
        .err     (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mm[i]) mm[i] = '0;
        mq   = '0;
        mqv  = 1'b0;
        merr = 1'b0;
        mcnt = DEP;
    endtask

    // One clock edge of the model, using the inputs currently applied.
    task automatic model_edge();
        if (mcnt > 0) begin
            mcnt--;
            mqv  = 1'b0;
            merr = 1'b0;
        end else begin
            merr = (load && (int'(waddr) >= DEP)) || (ren && (int'(raddr) >= DEP));
            mqv  = ren;
            if (ren) begin
                if (int'(raddr) >= DEP)                mq = '0;
                else if (load && (waddr == raddr))     mq = d;
                else                                   mq = mm[raddr[3:0]];
            end
            if (load && (int'(waddr) < DEP)) mm[waddr[3:0]] = d;
            if (clr) begin
                mcnt = DEP;
                foreach (mm[i]) mm[i] = '0;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, check all outputs.
    task automatic cyc(input logic c, input logic l, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
        clr   = c;
        load  = l;
        waddr = wa;
        d     = wd;
        ren   = r;
        raddr = ra;
        @(posedge clk);
        model_edge();
        #1;
        chk("q", 32'(q), 32'(mq));
        chk("q_valid", 32'(q_valid), 32'(mqv));
        chk("err", 32'(err), 32'(merr));
        chk("busy", 32'(busy), (mcnt > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Hold reset for two edges, checking the asynchronous reset values.
    task automatic do_reset();
        clr  = 1'b0;
        load = 1'b0;
        ren  = 1'b0;
        rst  = 1'b1;
        #1;
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_q_valid", 32'(q_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Count edges until busy falls; optional random traffic that must be ignored.
    task automatic count_busy(input bit noisy, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (noisy) cyc(1'b0, 1'($urandom), 5'($urandom), 16'($urandom),
                           1'($urandom), 5'($urandom));
            else       idle();
            n++;
            if (noisy) chk("sweep_q_valid", 32'(q_valid), 32'd0);
            if (!busy) break;
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < DEP; a++) begin
            cyc(1'b0, 1'b0, '0, '0, 1'b1, 5'(a));
            chk(tag, 32'(q), 32'd0);
        end
    endtask

    initial begin
        int n;

        waddr = '0;
        raddr = '0;
        d     = '0;
        model_reset();
        do_reset();

        // T1: sweep after reset lasts 16 edges, memory reads back zero.
        count_busy(1'b0, n);
        chk("t1_busy_len", 32'(n), 32'd16);
        read_all_zero("t1_read0");

        // T2-T4: fixed vectors.
        tbl[0] = '{1'b0, 1'b1, 5'h03, 16'h0055, 1'b0, 5'h00, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 5'h03, 16'h0055, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 5'h04, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 5'h07, 16'hBEEF, 1'b1, 5'h07, 16'hBEEF, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 5'h07, 16'hBEEF, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 5'h12, 16'h1234, 1'b0, 5'h00, 16'hBEEF, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 5'h12, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 5'h02, 16'h0000, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 5'h00, 16'h0000, 1'b1, 5'h03, 16'h0055, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 5'h00, 16'h0000, 1'b0, 5'h00, 16'h0055, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].c, tbl[i].l, tbl[i].wa, tbl[i].wd, tbl[i].r, tbl[i].ra);
            chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].eq));
            chk($sformatf("tbl%0d_q_valid", i), 32'(q_valid), 32'(tbl[i].eqv));
            chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].eerr));
        end

        // T5: fill, clear with noisy traffic, everything reads zero.
        for (int a = 0; a < DEP; a++) cyc(1'b0, 1'b1, 5'(a), 16'hA5A5, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 5'h09);
        chk("t5_fill", 32'(q), 32'h0000A5A5);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
        count_busy(1'b1, n);
        chk("t5_busy_len", 32'(n), 32'd16);
        read_all_zero("t5_read0");

        // T6: reset in the middle of a sweep restarts it.
        cyc(1'b1, 1'b1, 5'h05, 16'h1111, 1'b1, 5'h05);
        chk("t6_bypass", 32'(q), 32'h00001111);
        repeat (8) idle();
        do_reset();
        count_busy(1'b0, n);
        chk("t6_busy_len", 32'(n), 32'd16);

        // Random traffic, collision-biased, occasional clears.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] wa, ra;
            wa = 5'($urandom);
            ra = ($urandom_range(3) == 0) ? wa : 5'($urandom);
            cyc(($urandom_range(49) == 0), 1'($urandom), wa, 16'($urandom),
                1'($urandom), ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
